// File: rtl/de_regfile_sb.sv
// de_regfile_sb: decode-stage register file, CSR bank and RAW scoreboard.
// Commits writeback-bus writes, serves write-first bypassed reads and keeps
// a small busy counter per register so DE can hold on read-after-write hazards.
module de_regfile_sb #(
    parameter int                   DBITS     = 32,
    parameter int                   REGNOBITS = 5,
    parameter int                   CSRNOBITS = 12,
    parameter logic [CSRNOBITS-1:0] CSR_BASE  = 12'h7C0,
    parameter int                   CNTBITS   = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [REGNOBITS+DBITS+CSRNOBITS+1:0] from_WB_to_DE,
    input  logic [REGNOBITS-1:0]             rs1,
    input  logic [REGNOBITS-1:0]             rs2,
    input  logic                             use_rs1,
    input  logic                             use_rs2,
    output logic [DBITS-1:0]                 rs1_val,
    output logic [DBITS-1:0]                 rs2_val,
    input  logic [CSRNOBITS-1:0]             csr_rdno,
    output logic [DBITS-1:0]                 csr_rdval,
    input  logic                             issue_valid,
    input  logic                             issue_wr_reg,
    input  logic [REGNOBITS-1:0]             issue_rd,
    output logic                             stall,
    output logic                             sb_overflow,
    output logic [DBITS-1:0]                 wb_write_count
);

    localparam int NREGS = 1 << REGNOBITS;
    localparam int NCSR  = 4;
    localparam logic [CNTBITS-1:0] CNT_MAX = CNTBITS'((1 << CNTBITS) - 1);

    typedef struct packed {
        logic                 wr_reg;
        logic [REGNOBITS-1:0] wregno;
        logic [DBITS-1:0]     regval;
        logic [CSRNOBITS-1:0] wcsrno;
        logic                 wr_csr;
    } wb_bus_t;

    wb_bus_t wb;
    assign wb = from_WB_to_DE;

    logic [DBITS-1:0]   regs_q [NREGS];
    logic [DBITS-1:0]   regs_d [NREGS];
    logic [DBITS-1:0]   csr_q  [NCSR];
    logic [DBITS-1:0]   csr_d  [NCSR];
    logic [CNTBITS-1:0] cnt_q  [NREGS];
    logic [CNTBITS-1:0] cnt_d  [NREGS];
    logic               sb_overflow_q, sb_overflow_d;
    logic [DBITS-1:0]   wb_write_count_q, wb_write_count_d;

    logic                 rel;
    logic                 claim;
    logic [NREGS-1:0]     busy;
    logic [CSRNOBITS-1:0] csr_wr_off;
    logic [CSRNOBITS-1:0] csr_rd_off;
    logic                 csr_wr_hit;
    logic                 csr_rd_map;

    // Decode the writeback bus: register release and CSR address mapping.
    always_comb begin
        rel        = wb.wr_reg && (wb.wregno != '0);
        csr_wr_off = wb.wcsrno - CSR_BASE;
        csr_rd_off = csr_rdno - CSR_BASE;
        csr_wr_hit = wb.wr_csr && (csr_wr_off < CSRNOBITS'(NCSR));
        csr_rd_map = csr_rd_off < CSRNOBITS'(NCSR);
    end

    // Hazard detection: a register is busy unless this cycle's release retires its last claim.
    always_comb begin
        busy = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy[r] = (cnt_q[r] != '0) &&
                      !(rel && (wb.wregno == REGNOBITS'(r)) && (cnt_q[r] == CNTBITS'(1)));
        end
        stall = issue_valid &&
                ((use_rs1 && (rs1 != '0) && busy[rs1]) ||
                 (use_rs2 && (rs2 != '0) && busy[rs2]));
        claim = issue_valid && !stall && issue_wr_reg && (issue_rd != '0);
    end

    // Source and CSR reads with write-first bypass from the writeback bus.
    always_comb begin
        if (rs1 == '0)                             rs1_val = '0;
        else if (rel && (wb.wregno == rs1))        rs1_val = wb.regval;
        else                                       rs1_val = regs_q[rs1];

        if (rs2 == '0)                             rs2_val = '0;
        else if (rel && (wb.wregno == rs2))        rs2_val = wb.regval;
        else                                       rs2_val = regs_q[rs2];

        if (!csr_rd_map)                           csr_rdval = '0;
        else if (wb.wr_csr && (wb.wcsrno == csr_rdno)) csr_rdval = wb.regval;
        else                                       csr_rdval = csr_q[csr_rd_off[1:0]];
    end

    // Next-state: register/CSR commit, write counter, busy counters and overflow flag.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        regs_d           = regs_q;
        csr_d            = csr_q;
        cnt_d            = cnt_q;
        sb_overflow_d    = sb_overflow_q;
        wb_write_count_d = wb_write_count_q;

        if (rel) begin
            regs_d[wb.wregno] = wb.regval;
            wb_write_count_d  = wb_write_count_q + DBITS'(1);
        end

        if (csr_wr_hit) begin
            csr_d[csr_wr_off[1:0]] = wb.regval;
        end

        // x0 is never claimed or released, so its counter stays at zero.
        for (int r = 1; r < NREGS; r++) begin
            if (claim && (issue_rd == REGNOBITS'(r)) &&
                !(rel && (wb.wregno == REGNOBITS'(r)))) begin
                if (cnt_q[r] == CNT_MAX) sb_overflow_d = 1'b1;
                else                     cnt_d[r] = cnt_q[r] + CNTBITS'(1);
            end else if (rel && (wb.wregno == REGNOBITS'(r)) &&
                         !(claim && (issue_rd == REGNOBITS'(r))) &&
                         (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNTBITS'(1);
            end
        end
    end

    // State registers with synchronous active-low reset taking priority over all updates.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (!reset) begin
            // NOTE: the register and CSR arrays are reset too; software relies on them reading 0.
            regs_q           <= '{default: '0};
            csr_q            <= '{default: '0};
            cnt_q            <= '{default: '0};
            sb_overflow_q    <= 1'b0;
            wb_write_count_q <= '0;
        end else begin
            regs_q           <= regs_d;
            csr_q            <= csr_d;
            cnt_q            <= cnt_d;
            sb_overflow_q    <= sb_overflow_d;
            wb_write_count_q <= wb_write_count_d;
        end
    end

    assign sb_overflow    = sb_overflow_q;
    assign wb_write_count = wb_write_count_q;

endmodule
